// File: rtl/sme_host.sv
// sme_host: initiator side of the string-matching engine byte-stream link.
// Holds one string and one pattern, streams them to the engine, then waits
// for the engine result (or a timeout) and hands it upstream.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | buffers writable, waiting for an acceptable start
//   SEND_STR | streaming string chars (isstring=1)
//   SEND_PAT | streaming pattern chars (ispattern=1)
//   WAIT     | gap/idle drive, waiting for engine valid or timeout
//   RESULT   | res_valid=1 held until res_ready
module sme_host #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       buf_clr,
  input  logic       start,
  input  logic       new_str,
  output logic       busy,
  output logic [5:0] str_len,
  output logic [3:0] pat_len,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND_STR = 3'd1;
  localparam logic [2:0] SEND_PAT = 3'd2;
  localparam logic [2:0] WAIT     = 3'd3;
  localparam logic [2:0] RESULT   = 3'd4;

  localparam int SW = $clog2(STR_MAX);
  localparam int PW = $clog2(PAT_MAX);
  localparam int TW = $clog2(TIMEOUT);

  logic [2:0]    state;
  logic [7:0]    str_mem [STR_MAX];
  logic [7:0]    pat_mem [PAT_MAX];
  logic [5:0]    idx;
  logic [TW-1:0] tmr;
  logic          str_full;
  logic          pat_full;
  logic          load_ok;
  logic          start_ok;

  assign busy     = (state != IDLE);
  assign str_full = (str_len == 6'(STR_MAX));
  assign pat_full = (pat_len == 4'(PAT_MAX));
  assign load_ok  = reset && (state == IDLE) && !buf_clr && wr_en;
  assign start_ok = start && (pat_len != 4'd0) && (!new_str || (str_len != 6'd0));

  // Buffer storage; lengths live with the FSM so only the data is written here.
  always_ff @(posedge clk) begin
    if (load_ok && !wr_sel && !str_full) str_mem[str_len[SW-1:0]] <= wr_data;
    if (load_ok &&  wr_sel && !pat_full) pat_mem[pat_len[PW-1:0]] <= wr_data;
  end

  // Job sequencer with registered engine drive and result capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      str_len     <= '0;
      pat_len     <= '0;
      chardata    <= '0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= '0;
      res_timeout <= 1'b0;
      idx         <= '0;
      tmr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (buf_clr) begin
            str_len <= '0;
            pat_len <= '0;
          end else if (wr_en) begin
            if (!wr_sel && !str_full) str_len <= str_len + 6'd1;
            if ( wr_sel && !pat_full) pat_len <= pat_len + 4'd1;
          end
          if (start_ok) begin
            idx <= 6'd1;
            if (new_str) begin
              state    <= SEND_STR;
              isstring <= 1'b1;
              chardata <= str_mem[0];
            end else begin
              state     <= SEND_PAT;
              ispattern <= 1'b1;
              chardata  <= pat_mem[0];
            end
          end
        end
        SEND_STR: begin
          if (idx == str_len) begin
            state     <= SEND_PAT;
            isstring  <= 1'b0;
            ispattern <= 1'b1;
            chardata  <= pat_mem[0];
            idx       <= 6'd1;
          end else begin
            chardata <= str_mem[idx[SW-1:0]];
            idx      <= idx + 6'd1;
          end
        end
        SEND_PAT: begin
          if (idx == {2'b00, pat_len}) begin
            state     <= WAIT;
            ispattern <= 1'b0;
            chardata  <= '0;
            tmr       <= TW'(TIMEOUT - 1);
          end else begin
            chardata <= pat_mem[idx[PW-1:0]];
            idx      <= idx + 6'd1;
          end
        end
        WAIT: begin
          // A valid on the last allowed cycle still wins over the timeout.
          if (valid) begin
            res_match   <= match;
            res_index   <= match_index;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= RESULT;
          end else if (tmr == '0) begin
            res_match   <= 1'b0;
            res_index   <= '0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= RESULT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        RESULT: begin
          // String is kept for reuse by a later new_str=0 job.
          if (res_ready) begin
            res_valid <= 1'b0;
            pat_len   <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_host.sv
// tb_sme_host: randomized and directed checks of sme_host against a
// queue-based model of the buffers and the expected per-cycle drive stream.
module tb_sme_host;

  logic       clk = 1'b0;
  logic       reset, wr_en, wr_sel, buf_clr, start, new_str;
  logic [7:0] wr_data;
  logic       busy, isstring, ispattern;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic [7:0] chardata;
  logic       valid, match, res_valid, res_ready, res_match, res_timeout;
  logic [4:0] match_index, res_index;

  int total = 0;
  int bad   = 0;

  logic [7:0] str_q[$];
  logic [7:0] pat_q[$];

  sme_host dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .buf_clr(buf_clr), .start(start), .new_str(new_str), .busy(busy),
    .str_len(str_len), .pat_len(pat_len), .chardata(chardata),
    .isstring(isstring), .ispattern(ispattern), .valid(valid), .match(match),
    .match_index(match_index), .res_valid(res_valid), .res_ready(res_ready),
    .res_match(res_match), .res_index(res_index), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lens();
    chk("str_len", 32'(str_len), 32'(str_q.size()));
    chk("pat_len", 32'(pat_len), 32'(pat_q.size()));
  endtask

  task automatic load(input bit sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    step();
    wr_en = 1'b0;
    if (!sel && str_q.size() < 32) str_q.push_back(d);
    if (sel && pat_q.size() < 8) pat_q.push_back(d);
    chk_lens();
  endtask

  task automatic load_s(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) load(sel, s[i]);
  endtask

  task automatic clear_bufs();
    buf_clr = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'h55;
    step();
    buf_clr = 1'b0; wr_en = 1'b0;
    str_q.delete(); pat_q.delete();
    chk_lens();
  endtask

  // vdelay: WAIT cycle (1-based) on which valid is raised; >64 means never.
  task automatic run_job(input bit ns, input int vdelay, input bit vm,
                         input logic [4:0] vi, input int rdelay);
    bit accept;
    bit exp_m, exp_to;
    logic [4:0] exp_i;
    int k;
    logic [7:0] seq_d[$];
    bit         seq_s[$];
    accept = (pat_q.size() != 0) && (!ns || str_q.size() != 0);
    if (ns) foreach (str_q[i]) begin seq_d.push_back(str_q[i]); seq_s.push_back(1'b1); end
    foreach (pat_q[i]) begin seq_d.push_back(pat_q[i]); seq_s.push_back(1'b0); end
    start = 1'b1; new_str = ns;
    step();
    start = 1'b0;
    if (!accept) begin
      chk("rej_busy", 32'(busy), 0);
      chk("rej_drive", {30'd0, isstring, ispattern}, 0);
      chk_lens();
      return;
    end
    foreach (seq_d[i]) begin
      chk("snd_busy", 32'(busy), 1);
      chk("snd_isstr", 32'(isstring), 32'(seq_s[i]));
      chk("snd_ispat", 32'(ispattern), 32'(!seq_s[i]));
      chk("snd_char", 32'(chardata), 32'(seq_d[i]));
      valid = 1'($urandom_range(0, 1)); match = 1'($urandom); match_index = 5'($urandom);
      step();
    end
    k = 1;
    forever begin
      chk("wait_drive", {22'd0, isstring, ispattern, chardata}, 0);
      chk("wait_nores", 32'(res_valid), 0);
      valid = (k == vdelay); match = vm; match_index = vi;
      step();
      valid = 1'b0;
      if (k == vdelay || k == 64) break;
      k++;
    end
    exp_to = (vdelay > 64);
    exp_m  = exp_to ? 1'b0 : vm;
    exp_i  = exp_to ? 5'd0 : vi;
    for (int r = 0; r <= rdelay; r++) begin
      chk("res_valid", 32'(res_valid), 1);
      chk("res_match", 32'(res_match), 32'(exp_m));
      chk("res_index", 32'(res_index), 32'(exp_i));
      chk("res_timeout", 32'(res_timeout), 32'(exp_to));
      chk("res_busy", 32'(busy), 1);
      chk_lens();
      if (r < rdelay) begin
        start = 1'($urandom); new_str = 1'($urandom);
        wr_en = 1'($urandom); wr_sel = 1'($urandom); wr_data = 8'($urandom);
        res_ready = 1'b0;
      end else begin
        start = 1'b0; wr_en = 1'b0; res_ready = 1'b1;
      end
      step();
    end
    res_ready = 1'b0;
    pat_q.delete();
    chk("done_valid", 32'(res_valid), 0);
    chk("done_busy", 32'(busy), 0);
    chk_lens();
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0; buf_clr = 1'b0;
    start = 1'b0; new_str = 1'b0; valid = 1'b0; match = 1'b0; match_index = '0;
    res_ready = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk_lens();
    chk("rst_drive", {22'd0, isstring, ispattern, chardata}, 0);
    chk("rst_res", {24'd0, res_valid, res_match, res_index, res_timeout}, 0);
    reset = 1'b1;
    step();

    load_s(1'b0, "hello world");
    load_s(1'b1, "wor");
    run_job(1'b1, 3, 1'b1, 5'd6, 0);
    load_s(1'b1, "^he");
    run_job(1'b0, 1, 1'b1, 5'd0, 0);
    chk("reuse_str", 32'(str_len), 11);

    run_job(1'b0, 2, 1'b0, 5'd0, 0);
    clear_bufs();
    load_s(1'b1, "ab");
    run_job(1'b1, 2, 1'b0, 5'd0, 0);
    run_job(1'b0, 100, 1'b1, 5'd9, 5);
    load_s(1'b1, "xyz");
    run_job(1'b0, 64, 1'b1, 5'd17, 2);

    for (int it = 0; it < 30; it++) begin
      int ns_chars, np_chars;
      if ($urandom_range(0, 3) == 0) clear_bufs();
      ns_chars = (str_q.size() == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(0, 35) : 0;
      np_chars = $urandom_range(0, 10);
      for (int i = 0; i < ns_chars; i++) load(1'b0, 8'($urandom));
      for (int i = 0; i < np_chars; i++) load(1'b1, 8'($urandom));
      run_job(1'($urandom), $urandom_range(1, 70), 1'($urandom), 5'($urandom),
              $urandom_range(0, 4));
    end

    if (str_q.size() == 0) load(1'b0, 8'h41);
    if (pat_q.size() == 0) load(1'b1, 8'h42);
    start = 1'b1; new_str = 1'b1;
    step();
    start = 1'b0;
    chk("mid_isstr", 32'(isstring), 1);
    reset = 1'b0;
    step();
    str_q.delete(); pat_q.delete();
    chk("mid_rst_isstr", 32'(isstring), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rv", 32'(res_valid), 0);
    chk_lens();
    reset = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
